// File: rtl/icache_fetch_unit.sv
// Direct-mapped, one-word-per-line instruction cache.
// A miss holds a single-word request to the memory controller until it completes.
module icache_fetch_unit #(
    parameter int INDEX_BITS = 8,
    parameter int ADDR_WIDTH = 32
) (
    input  logic                  clk_in,
    input  logic                  rst_in,
    input  logic                  rdy_in,
    input  logic                  clear,
    input  logic                  if_req_i,
    input  logic [ADDR_WIDTH-1:0] if_pc_i,
    output logic                  if_valid_o,
    output logic [31:0]           if_inst_o,
    output logic                  mem_en_o,
    output logic [ADDR_WIDTH-1:0] mem_addr_o,
    input  logic                  mem_en_i,
    input  logic [31:0]           mem_data_i
);

    localparam int LINES = 1 << INDEX_BITS;
    localparam int TAG_W = ADDR_WIDTH - INDEX_BITS - 2;

    typedef enum logic [1:0] {IDLE, MISS, RESP} state_t;

    state_t state, state_d;

    logic [LINES-1:0] valid_q;
    logic [TAG_W-1:0] tag_arr [LINES];
    logic [31:0]      data_arr [LINES];

    logic [ADDR_WIDTH-1:0] pc_al;
    logic [INDEX_BITS-1:0] idx, f_idx;
    logic [TAG_W-1:0]      tag, f_tag;
    logic                  hit, fill;

    logic                  valid_d, en_d;
    logic [31:0]           inst_d;
    logic [ADDR_WIDTH-1:0] addr_d;

    assign pc_al = if_pc_i & ~ADDR_WIDTH'(3);
    assign idx   = pc_al[INDEX_BITS+1:2];
    assign tag   = pc_al[ADDR_WIDTH-1:INDEX_BITS+2];
    assign hit   = valid_q[idx] && (tag_arr[idx] == tag);

    // The pending miss address lives in mem_addr_o, so fills index from it.
    assign f_idx = mem_addr_o[INDEX_BITS+1:2];
    assign f_tag = mem_addr_o[ADDR_WIDTH-1:INDEX_BITS+2];
    assign fill  = (state == MISS) && mem_en_i && (rdy_in || clear);

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            state      <= IDLE;
            valid_q    <= '0;
            if_valid_o <= 1'b0;
            if_inst_o  <= '0;
            mem_en_o   <= 1'b0;
            mem_addr_o <= '0;
        end else begin
            if (fill) valid_q[f_idx] <= 1'b1;
            if (rdy_in || clear) begin
                state      <= state_d;
                if_valid_o <= valid_d;
                if_inst_o  <= inst_d;
                mem_en_o   <= en_d;
                mem_addr_o <= addr_d;
            end
        end
    end

    always_ff @(posedge clk_in) begin
        if (!rst_in && fill) begin
            tag_arr[f_idx]  <= f_tag;
            data_arr[f_idx] <= mem_data_i;
        end
    end

    always_comb begin
        state_d = state;
        unique case (state)
            IDLE: if (if_req_i) state_d = hit ? RESP : MISS;
            MISS: if (mem_en_i) state_d = RESP;
            RESP: state_d = IDLE;
            default: state_d = IDLE;
        endcase
        if (clear) state_d = IDLE;
    end

    always_comb begin
        valid_d = 1'b0;
        inst_d  = if_inst_o;
        en_d    = mem_en_o;
        addr_d  = mem_addr_o;
        unique case (state)
            IDLE: begin
                if (if_req_i && hit) begin
                    inst_d  = data_arr[idx];
                    valid_d = 1'b1;
                end else if (if_req_i) begin
                    addr_d = pc_al;
                    en_d   = 1'b1;
                end
            end
            MISS: begin
                if (mem_en_i) begin
                    inst_d  = mem_data_i;
                    valid_d = 1'b1;
                    en_d    = 1'b0;
                end
            end
            default: ;
        endcase
        // A flush still lets the fill land but suppresses the response.
        if (clear) begin
            valid_d = 1'b0;
            en_d    = 1'b0;
            addr_d  = '0;
        end
    end

endmodule
